// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_pkg
// Description : Shared SoC types and constants. Holds the OBI subordinate-port
//               request/response structs (32-bit address/data, 1-bit ID) and
//               the manager-count constants used by obi_mgr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_pkg;

   localparam int unsigned AddrWidth   = 32;
   localparam int unsigned DataWidth   = 32;
   localparam int unsigned IdWidth     = 1;

   // Number of managers sharing the peripheral crossbar port.
   localparam int unsigned NumMgrs     = 2;
   localparam int unsigned MgrIdxWidth = $clog2(NumMgrs);

   typedef struct packed {
      logic [AddrWidth-1:0]   addr;
      logic                   we;
      logic [DataWidth/8-1:0] be;
      logic [DataWidth-1:0]   wdata;
      logic [IdWidth-1:0]     aid;
   } obi_a_chan_t;

   typedef struct packed {
      logic [DataWidth-1:0] rdata;
      logic [IdWidth-1:0]   rid;
      logic                 err;
   } obi_r_chan_t;

   typedef struct packed {
      logic        req;
      obi_a_chan_t a;
   } sbr_obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic        rready;
      obi_r_chan_t r;
   } sbr_obi_rsp_t;

endpackage : soc_pkg
`default_nettype wire

// File: rtl/obi_arb_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : obi_arb_order_fifo
// Description : First-word-fall-through FIFO holding the manager index of each
//               accepted-but-unanswered OBI transaction, in grant order.
// Revision    : 1.0 - initial release
// Ports       : clk_i    - clock
//               rst_i    - asynchronous active-high reset
//               push_i   - write data_i (ignored when full)
//               pop_i    - drop head entry (ignored when empty)
//               data_i   - manager index to store
//               data_o   - head entry (valid when !empty_o)
//               full_o   - DEPTH entries stored
//               empty_o  - no entries stored
//               count_o  - registered fill level
// ============================================================================
module obi_arb_order_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned        CNT_W    = $clog2(DEPTH + 1);
   localparam int unsigned        PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full_o    = (r_count == CNT_FULL);
   assign empty_o   = (r_count == '0);
   assign count_o   = r_count;
   assign data_o    = r_mem[r_rd_ptr];
   // A push into a full FIFO is refused even if a pop frees a slot this cycle.
   assign w_do_push = push_i && !full_o;
   assign w_do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
            r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

endmodule : obi_arb_order_fifo
`default_nettype wire

// File: rtl/obi_mgr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : obi_mgr_arbiter
// Description : Round-robin arbiter sharing one OBI subordinate port between
//               NumMgr managers. Serialises address phases, records grant
//               order and routes in-order responses back to their owners.
// Revision    : 1.0 - initial release
// Ports       : clk_i         - clock
//               rst_i         - asynchronous active-high reset
//               mgr_req_i     - per-manager OBI requests
//               mgr_rsp_o     - per-manager OBI responses (rready driven 0)
//               mgr_rready_i  - per-manager response ready
//               sbr_req_o     - request to the subordinate / crossbar
//               sbr_rsp_i     - subordinate response (rready ignored)
//               sbr_rready_o  - response ready to the subordinate
//               outstanding_o - registered order-FIFO fill level
//               proto_err_o   - sticky: rvalid seen with nothing outstanding
// ============================================================================
module obi_mgr_arbiter
   import soc_pkg::*;
#(
   parameter int unsigned NumMgr         = NumMgrs,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  sbr_obi_req_t                        mgr_req_i [NumMgr],
   output sbr_obi_rsp_t                        mgr_rsp_o [NumMgr],
   input  logic [NumMgr-1:0]                   mgr_rready_i,
   output sbr_obi_req_t                        sbr_req_o,
   input  sbr_obi_rsp_t                        sbr_rsp_i,
   output logic                                sbr_rready_o,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
   output logic                                proto_err_o
);

   localparam int unsigned      IDX_W    = (NumMgr > 1) ? $clog2(NumMgr) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NumMgr - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_d;
   logic [IDX_W-1:0] r_sel;
   logic [IDX_W-1:0] w_sel_d;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] w_rr_next;
   logic             r_proto_err;
   logic [NumMgr-1:0] w_req_vec;
   logic [IDX_W-1:0] w_pick;
   logic [IDX_W-1:0] w_cur;
   logic             w_present;
   logic             w_hs;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [IDX_W-1:0] w_head;
   logic             w_unused_rready;

   // First requester at or after ptr, wrapping. Iterating from the farthest
   // offset down lets the nearest requester overwrite the result last.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NumMgr-1:0] reqs,
                                                input logic [IDX_W-1:0]  ptr);
      logic [IDX_W-1:0] pick;
      int               idx;
      pick = ptr;
      for (int i = int'(NumMgr) - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % int'(NumMgr);
         if (reqs[IDX_W'(idx)]) begin
            pick = IDX_W'(idx);
         end
      end
      return pick;
   endfunction

   always_comb begin
      w_req_vec = '0;
      for (int i = 0; i < int'(NumMgr); i++) begin
         w_req_vec[i] = mgr_req_i[i].req;
      end
   end

   assign w_pick          = rr_pick(w_req_vec, r_rr_ptr);
   assign w_hs            = sbr_req_o.req && sbr_rsp_i.gnt;
   assign w_rr_next       = (w_cur == IDX_LAST) ? '0 : w_cur + 1'b1;
   assign w_pop           = sbr_rsp_i.rvalid && sbr_rready_o && !w_empty;
   assign proto_err_o     = r_proto_err;
   assign w_unused_rready = sbr_rsp_i.rready;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_sel       <= '0;
         r_rr_ptr    <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_sel   <= w_sel_d;
         if (w_hs) begin
            r_rr_ptr <= w_rr_next;
         end
         if (sbr_rsp_i.rvalid && w_empty) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   // Next-state logic. HOLD is only entered with a free slot, so it skips the
   // full check and keeps presenting the locked manager until granted.
   always_comb begin
      w_state_d = r_state;
      w_sel_d   = r_sel;
      w_present = 1'b0;
      w_cur     = w_pick;
      case (r_state)
         ST_IDLE: begin
            w_present = (|w_req_vec) && !w_full;
            if (w_present && !sbr_rsp_i.gnt) begin
               w_state_d = ST_HOLD;
               w_sel_d   = w_pick;
            end
         end
         ST_HOLD: begin
            w_present = 1'b1;
            w_cur     = r_sel;
            if (sbr_rsp_i.gnt) begin
               w_state_d = ST_IDLE;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
      // Outputs must read as reset values while reset is held, even if a
      // manager keeps its request asserted.
      if (rst_i) begin
         w_present = 1'b0;
      end
   end

   // Output logic
   always_comb begin
      sbr_req_o    = '0;
      sbr_rready_o = 1'b1;
      for (int k = 0; k < int'(NumMgr); k++) begin
         mgr_rsp_o[k] = '0;
      end
      if (w_present) begin
         sbr_req_o               = mgr_req_i[w_cur];
         mgr_rsp_o[w_cur].gnt    = sbr_rsp_i.gnt;
      end
      if (!w_empty) begin
         mgr_rsp_o[w_head].rvalid = sbr_rsp_i.rvalid;
         mgr_rsp_o[w_head].r      = sbr_rsp_i.r;
         sbr_rready_o             = mgr_rready_i[w_head];
      end
   end

   obi_arb_order_fifo #(
      .DEPTH (MaxOutstanding),
      .WIDTH (IDX_W)
   ) u_order_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_hs),
      .pop_i   (w_pop),
      .data_i  (w_cur),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (outstanding_o)
   );

endmodule : obi_mgr_arbiter
`default_nettype wire

// File: tb/tb_obi_mgr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_mgr_arbiter
// Description : Self-checking bench for obi_mgr_arbiter. A driver issues
//               random manager/subordinate traffic and pushes expected
//               presentations and response beats into queues; a monitor on
//               the falling edge pops and compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_mgr_arbiter;
   import soc_pkg::*;

   localparam int N    = 2;
   localparam int MAXO = 2;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   sbr_obi_req_t                 mgr_req [N];
   sbr_obi_rsp_t                 mgr_rsp [N];
   logic [N-1:0]                 mgr_rready;
   sbr_obi_req_t                 sbr_req;
   sbr_obi_rsp_t                 sbr_rsp;
   logic                         sbr_rready;
   logic [$clog2(MAXO+1)-1:0]    outstanding;
   logic                         proto_err;

   always #5 clk = ~clk;

   obi_mgr_arbiter #(
      .NumMgr         (N),
      .MaxOutstanding (MAXO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .mgr_req_i     (mgr_req),
      .mgr_rsp_o     (mgr_rsp),
      .mgr_rready_i  (mgr_rready),
      .sbr_req_o     (sbr_req),
      .sbr_rsp_i     (sbr_rsp),
      .sbr_rready_o  (sbr_rready),
      .outstanding_o (outstanding),
      .proto_err_o   (proto_err)
   );

   typedef struct { int mgr; obi_a_chan_t a; bit gnt; } exp_req_t;
   typedef struct { int mgr; obi_r_chan_t r; } exp_rsp_t;

   exp_req_t    exp_req_q [$];
   exp_rsp_t    exp_rsp_q [$];

   // Reference model: arbitration rules expressed with integers and a queue.
   int          rr_ptr;
   bit          hold;
   int          hold_mgr;
   int          order_q [$];
   bit          exp_perr;
   bit          exp_perr_now;
   int          exp_outst;
   bit          exp_rready;
   bit          pending [N];
   obi_a_chan_t pend_a [N];

   int          p_req, p_gnt, p_rv;
   bit          force_err_rv;
   bit          mon_en = 1'b0;

   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void fail_now(string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got event with empty expectation queue, required none", name);
   endfunction

   function automatic obi_a_chan_t rand_a();
      obi_a_chan_t a;
      a.addr  = $urandom;
      a.we    = 1'($urandom_range(1));
      a.be    = 4'($urandom_range(15));
      a.wdata = $urandom;
      a.aid   = IdWidth'($urandom_range(1));
      return a;
   endfunction

   function automatic obi_r_chan_t rand_r();
      obi_r_chan_t r;
      r.rdata = $urandom;
      r.rid   = IdWidth'($urandom_range(1));
      r.err   = 1'($urandom_range(1));
      return r;
   endfunction

   task automatic reset_model();
      rr_ptr   = 0;
      hold     = 1'b0;
      hold_mgr = 0;
      order_q.delete();
      exp_perr = 1'b0;
      for (int i = 0; i < N; i++) pending[i] = 1'b0;
   endtask

   // Drive one cycle of stimulus and record what the DUT must do with it.
   task automatic drive_cycle();
      bit present;
      int sel;
      int h;
      for (int i = 0; i < N; i++) begin
         if (!pending[i] && $urandom_range(99) < p_req) begin
            pending[i] = 1'b1;
            pend_a[i]  = rand_a();
         end
         mgr_req[i].req = pending[i];
         mgr_req[i].a   = pending[i] ? pend_a[i] : rand_a();
         mgr_rready[i]  = ($urandom_range(99) < 70);
      end
      sbr_rsp.gnt    = ($urandom_range(99) < p_gnt);
      sbr_rsp.rvalid = ((order_q.size() > 0) && ($urandom_range(99) < p_rv)) || force_err_rv;
      sbr_rsp.rready = 1'($urandom_range(1));
      sbr_rsp.r      = rand_r();

      present = 1'b0;
      sel     = 0;
      if (hold) begin
         present = 1'b1;
         sel     = hold_mgr;
      end else if (order_q.size() < MAXO) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (rr_ptr + k) % N;
            if (!present && pending[c]) begin
               present = 1'b1;
               sel     = c;
            end
         end
      end

      exp_outst    = order_q.size();
      exp_perr_now = exp_perr;
      if (present) exp_req_q.push_back('{mgr: sel, a: pend_a[sel], gnt: sbr_rsp.gnt});

      if (order_q.size() > 0) begin
         h          = order_q[0];
         exp_rready = mgr_rready[h];
         if (sbr_rsp.rvalid && mgr_rready[h]) begin
            exp_rsp_q.push_back('{mgr: h, r: sbr_rsp.r});
            void'(order_q.pop_front());
         end
      end else begin
         exp_rready = 1'b1;
         if (sbr_rsp.rvalid) exp_perr = 1'b1;
      end

      if (present && sbr_rsp.gnt) begin
         order_q.push_back(sel);
         rr_ptr       = (sel + 1) % N;
         hold         = 1'b0;
         pending[sel] = 1'b0;
      end else if (present) begin
         hold     = 1'b1;
         hold_mgr = sel;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive_cycle();
      mon_en = 1'b1;
   endtask

   task automatic drain();
      int  budget;
      bit  busy;
      p_req  = 0;
      p_gnt  = 100;
      p_rv   = 100;
      budget = 0;
      busy   = 1'b1;
      while (busy && budget < 300) begin
         step();
         budget++;
         busy = hold || (order_q.size() > 0);
         for (int i = 0; i < N; i++) busy = busy || pending[i];
      end
      check("drain_done", busy, 1'b0);
   endtask

   task automatic stop_monitor();
      @(negedge clk);
      #1;
      mon_en = 1'b0;
   endtask

   // Monitor: compares on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         logic [N-1:0] gv;
         logic [N-1:0] gexp;
         exp_req_t     er;
         exp_rsp_t     es;
         check("outstanding", outstanding, exp_outst);
         check("sbr_rready", sbr_rready, exp_rready);
         check("proto_err", proto_err, exp_perr_now);
         gv = '0;
         for (int k = 0; k < N; k++) gv[k] = mgr_rsp[k].gnt;
         if (sbr_req.req) begin
            if (exp_req_q.size() == 0) begin
               fail_now("unexpected_req");
            end else begin
               er   = exp_req_q.pop_front();
               gexp = er.gnt ? N'(1 << er.mgr) : '0;
               check("req_a", sbr_req.a, er.a);
               check("gnt_route", gv, gexp);
            end
         end else begin
            check("gnt_without_req", gv, '0);
         end
         for (int k = 0; k < N; k++) begin
            if (mgr_rsp[k].rvalid && mgr_rready[k]) begin
               if (exp_rsp_q.size() == 0) begin
                  fail_now("unexpected_rsp");
               end else begin
                  es = exp_rsp_q.pop_front();
                  check("rsp_owner", k, es.mgr);
                  check("rsp_r", mgr_rsp[k].r, es.r);
               end
            end
         end
      end
   end

   initial begin
      obi_a_chan_t a1;
      obi_a_chan_t a0;
      for (int i = 0; i < N; i++) mgr_req[i] = '0;
      mgr_rready   = '1;
      sbr_rsp      = '0;
      force_err_rv = 1'b0;
      exp_outst    = 0;
      exp_rready   = 1'b1;
      exp_perr_now = 1'b0;
      reset_model();

      // Reset state, with a request and grant present to show outputs are held.
      repeat (3) @(posedge clk);
      #1;
      mgr_req[0].req = 1'b1;
      mgr_req[0].a   = rand_a();
      sbr_rsp.gnt    = 1'b1;
      sbr_rsp.rvalid = 1'b1;
      #1;
      check("rst_sbr_req", sbr_req, '0);
      check("rst_mgr_rsp0", mgr_rsp[0], '0);
      check("rst_mgr_rsp1", mgr_rsp[1], '0);
      check("rst_sbr_rready", sbr_rready, 1'b1);
      check("rst_outstanding", outstanding, 0);
      check("rst_proto_err", proto_err, 1'b0);
      mgr_req[0] = '0;
      sbr_rsp    = '0;
      @(negedge clk);
      rst = 1'b0;

      // Mixed random traffic, then saturated back-to-back, then slow grants.
      p_req = 60; p_gnt = 60; p_rv = 50;
      repeat (1500) step();
      p_req = 100; p_gnt = 100; p_rv = 100;
      repeat (60) step();
      p_req = 70; p_gnt = 25; p_rv = 30;
      repeat (500) step();
      drain();

      // Response with nothing outstanding: sticky protocol error.
      p_req = 0; p_rv = 0;
      force_err_rv = 1'b1;
      step();
      force_err_rv = 1'b0;
      repeat (6) step();
      stop_monitor();
      check("req_q_empty", exp_req_q.size(), 0);
      check("rsp_q_empty", exp_rsp_q.size(), 0);

      // Reset asserted while manager 1 is held waiting for grant.
      @(posedge clk);
      #1;
      sbr_rsp        = '0;
      mgr_rready     = '1;
      a1             = rand_a();
      mgr_req[0]     = '0;
      mgr_req[1].req = 1'b1;
      mgr_req[1].a   = a1;
      @(posedge clk);
      #1;
      a0             = rand_a();
      mgr_req[0].req = 1'b1;
      mgr_req[0].a   = a0;
      #1;
      check("hold_a", sbr_req.a, a1);
      check("hold_req", sbr_req.req, 1'b1);
      check("hold_perr_set", proto_err, 1'b1);
      rst = 1'b1;
      #1;
      check("midrst_sbr_req", sbr_req, '0);
      check("midrst_mgr_rsp0", mgr_rsp[0], '0);
      check("midrst_mgr_rsp1", mgr_rsp[1], '0);
      check("midrst_sbr_rready", sbr_rready, 1'b1);
      check("midrst_outstanding", outstanding, 0);
      check("midrst_proto_err", proto_err, 1'b0);
      for (int i = 0; i < N; i++) mgr_req[i] = '0;
      @(negedge clk);
      rst = 1'b0;

      // Fresh traffic after reset: pointer and FIFO must start from scratch.
      reset_model();
      p_req = 80; p_gnt = 50; p_rv = 50;
      repeat (300) step();
      drain();
      stop_monitor();
      check("req_q_empty_end", exp_req_q.size(), 0);
      check("rsp_q_empty_end", exp_rsp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_obi_mgr_arbiter
`default_nettype wire

// File: doc/obi_mgr_arbiter.md
# obi_mgr_arbiter

Round-robin arbiter that shares one OBI subordinate port (`sbr_obi_req_t`/`sbr_obi_rsp_t`, 32-bit address/data, 1-bit ID) between `NumMgr` managers. It sits between the managers (core instruction/data ports, debug, DMA) and the peripheral crossbar input. It serialises address phases, remembers grant order, and routes in-order responses back to the owning manager.

## Interface
- `NumMgr`, default 2: number of managers, 2..8.
- `MaxOutstanding`, default 2: accepted-but-unanswered transactions, 1..8; sets the order-FIFO depth.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `mgr_req_i` in `sbr_obi_req_t [NumMgr]`: manager requests.
- `mgr_rsp_o` out `sbr_obi_rsp_t [NumMgr]`: manager responses. The `rready` field is driven 0.
- `mgr_rready_i` in `[NumMgr]`: per-manager response ready.
- `sbr_req_o` out `sbr_obi_req_t`: request to the subordinate/crossbar.
- `sbr_rsp_i` in `sbr_obi_rsp_t`: subordinate response. The `rready` field is ignored.
- `sbr_rready_o` out 1: response ready to the subordinate.
- `outstanding_o` out `$clog2(MaxOutstanding+1)`: current order-FIFO fill level.
- `proto_err_o` out 1: sticky flag, set by an `rvalid` arriving while no transaction is outstanding.

## Operation
- States: IDLE (no request presented) and HOLD (request from locked manager `sel_q` presented, waiting for `gnt`).
- IDLE: if `outstanding < MaxOutstanding` and any `mgr_req_i[i].req`, pick the first requester at or after `rr_ptr_q`, wrapping modulo `NumMgr`. Present it the same cycle.
  - With `gnt` in the same cycle: stay in IDLE.
  - Without `gnt`: go to HOLD with `sel_q` set to that manager.
- HOLD: present `mgr_req_i[sel_q]` unconditionally; a manager must keep `req` and `a` stable until `gnt` (OBI rule). On `gnt`, return to IDLE.
- FIFO full in IDLE: `sbr_req_o.req = 0` and all manager `gnt = 0`. HOLD is only entered with a free slot, so it never needs a full check.
- `sbr_req_o.a` is a mux of the selected manager's `a`. `aid` and `be` pass through unchanged.
- `mgr_rsp_o[k].gnt = sbr_rsp_i.gnt` only for the presented manager `k`, else 0.
- On a handshake (`req && gnt`):
  - push `k` into the order FIFO;
  - `rr_ptr_q <= (k+1) mod NumMgr`.
- Response routing:
  - head `h` = FIFO head;
  - `mgr_rsp_o[h].rvalid = sbr_rsp_i.rvalid`, and `mgr_rsp_o[h].r = sbr_rsp_i.r`;
  - other managers get `rvalid = 0` and `r = '0`;
  - `sbr_rready_o = mgr_rready_i[h]` when the FIFO is non-empty, else 1.
- Pop on `rvalid && sbr_rready_o` with the FIFO non-empty.
- Push and pop in the same cycle are legal, including when the FIFO is full (pop frees the slot first for the count; the push is still blocked by the registered full check in IDLE).
- `rvalid` with the FIFO empty: the beat is accepted and dropped, and `proto_err_o` is set until reset.
- Reset mid-transaction: all state is discarded. Pending responses are then treated as protocol errors.

## Timing
- Reset values:
  - state IDLE, `rr_ptr_q` 0, `sel_q` 0, FIFO empty;
  - `outstanding_o` 0, `proto_err_o` 0;
  - `sbr_req_o` all 0, all `mgr_rsp_o` fields 0, `sbr_rready_o` 1.
- Request and grant paths are combinational: zero added cycles. A handshake on cycle t permits a new presentation on t+1 (back-to-back).
- Response path is combinational: zero added cycles.
- The full check uses the registered count: a slot freed by a pop at t is usable at t+1.
- `outstanding_o` is registered: it updates the cycle after a push or pop.

## Structure
- Add `NumMgrs` (default 2) and `MgrIdxWidth = $clog2(NumMgrs)` localparams to `soc_pkg`. Reuse `sbr_obi_req_t`/`sbr_obi_rsp_t` unchanged.
- Sub-module `obi_arb_order_fifo`: depth `MaxOutstanding`, width `MgrIdxWidth`, first-word-fall-through, same async active-high reset. Ports: push/pop/data/full/empty/count.
- The round-robin pick is a local function, not a module.

## Test plan
- Single manager 0 writes `addr 0x1000_0004`, `wdata 0xDEAD_BEEF`, and `gnt` is given the same cycle → `sbr_req_o` mirrors the request that cycle, `outstanding_o` = 1 next cycle, and `rvalid` one cycle later reaches manager 0 only.
- Both managers request continuously, `gnt` every cycle, `MaxOutstanding` 2, responses 1 cycle later → grants alternate 0,1,0,1 and each response reaches its owner.
- Manager 1 requests, `gnt` held low 3 cycles, manager 0 requests at cycle 1 → `sbr_req_o` stays manager 1's request with a stable address until `gnt`, then manager 0 is served.
- Two handshakes with responses withheld → `req` drops (FIFO full). A response with `mgr_rready_i` = 0 for 2 cycles stalls `sbr_rready_o`, and the next request is issued the cycle after the pop.
- `rvalid` = 1 with the FIFO empty → `proto_err_o` = 1 and stays set. Assert `rst_i` mid-HOLD → all outputs return to their reset values immediately.
